// File: rtl/signal_narrow_pkg.sv
// Shared types and constants for the 16-to-11-bit signed narrowing stream block.
// Holds the FSM state type, the default widths and the signed saturation limits.
package signal_narrow_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 11;

  // Largest positive value representable in 'width' signed bits.
  function automatic logic [31:0] sat_max(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Most negative value in 'width' signed bits, as its raw two's-complement pattern.
  function automatic logic [31:0] sat_min(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/signal_narrow_conv.sv
// Combinational range check and narrowing of one signed word.
// SIGNAL_NARROW_SATURATE_EN selects saturation of out-of-range words; otherwise they wrap.
module signal_narrow_conv
  import signal_narrow_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  data,
  output logic [OUT_WIDTH-1:0] narrow,
  output logic                 overflow
);

  // The word fits when every bit from the top down to the new sign bit is a sign copy.
  logic [IN_WIDTH-OUT_WIDTH:0] upper;
  assign upper    = data[IN_WIDTH-1:OUT_WIDTH-1];
  assign overflow = !((&upper) || !(|upper));

`ifdef SIGNAL_NARROW_SATURATE_EN
  localparam logic [OUT_WIDTH-1:0] SAT_HI = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] SAT_LO = OUT_WIDTH'(sat_min(OUT_WIDTH));

  assign narrow = !overflow          ? data[OUT_WIDTH-1:0] :
                  data[IN_WIDTH-1]   ? SAT_LO : SAT_HI;
`else
  assign narrow = data[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/signal_narrow.sv
// Valid/ready stream narrowing signed words with a 2-entry skid buffer and overflow counter.
// Optional build macro: SIGNAL_NARROW_SATURATE_EN (saturate instead of wrap on overflow).
module signal_narrow
  import signal_narrow_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [IN_WIDTH-1:0]  i_signal,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_signal,
  output logic                 o_overflow,
  output logic [CNT_WIDTH-1:0] o_ovf_count,
  input  logic                 i_clear_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state, state_next;
  logic [OUT_WIDTH-1:0] conv_word, out_word, skid_word;
  logic                 conv_ovf, out_ovf, skid_ovf;
  logic [CNT_WIDTH-1:0] ovf_count;
  logic                 in_xfer, out_xfer;
  logic                 load_out, load_skid, from_skid;

  signal_narrow_conv #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_conv (
    .data    (i_signal),
    .narrow  (conv_word),
    .overflow(conv_ovf)
  );

  // Both handshake outputs decode the state register only, so i_ready never reaches o_ready.
  assign o_valid  = (state != EMPTY);
  assign o_ready  = (state != FULL);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    from_skid  = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_next = BUSY;
        load_out   = 1'b1;
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: if (out_xfer) begin
        state_next = BUSY;
        from_skid  = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= EMPTY;
    else            state <= state_next;
  end

  // NOTE: the skid entry is reset too, so a discarded word can never reappear after reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_word  <= '0;
      out_ovf   <= 1'b0;
      skid_word <= '0;
      skid_ovf  <= 1'b0;
    end else begin
      if (from_skid) begin
        out_word <= skid_word;
        out_ovf  <= skid_ovf;
      end else if (load_out) begin
        out_word <= conv_word;
        out_ovf  <= conv_ovf;
      end
      if (load_skid) begin
        skid_word <= conv_word;
        skid_ovf  <= conv_ovf;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at its maximum.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_count <= '0;
    end else if (i_clear_count) begin
      ovf_count <= '0;
    end else if (out_xfer && out_ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

  assign o_signal    = out_word;
  assign o_overflow  = out_ovf;
  assign o_ovf_count = ovf_count;

endmodule
